// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multi-cycle core control path.
package rv32_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Sequencer states; encodings are visible on the debug state port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  // One-hot instruction class
  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } cls_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // Register-file write-back select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // True when the class touches the unified memory port after EXEC
  function automatic logic cls_is_mem(input cls_t c);
    return c.load | c.store;
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational major-opcode classifier: instr[6:0] -> one-hot class + illegal.
module mc_opcode_decode
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  // Map each supported major opcode onto exactly one class bit
  always_comb begin
    cls = '0;
    case (opcode)
      OPC_R:      cls.r      = 1'b1;
      OPC_I_ALU:  cls.i_alu  = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      default:    cls        = '0;
    endcase
  end

  assign illegal = ~(|cls);

endmodule

// File: rtl/mc_control_fsm.sv
// Main sequencer for the multi-cycle RV32I core.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request instruction at PC, wait for mem_ready, latch IR, PC+=4
// DECODE | classify opcode, load immediate, precompute branch target
// EXEC   | drive ALU for the class; branches resolve and retire here
// MEM    | load/store at ALU address, wait for mem_ready
// WB     | register-file write, JAL/JALR redirect PC
// TRAP   | illegal opcode seen; absorbing until reset
module mc_control_fsm
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            br_taken,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic [1:0]      alu_op,
  output logic            imm_en,
  output logic            illegal,
  output logic [2:0]      state,
  output logic [XLEN-1:0] instret,
  output logic [XLEN-1:0] pc_reset_val
);

  state_t          state_q;
  cls_t            cls_q;
  cls_t            cls_d;
  logic            dec_illegal;
  logic            illegal_q;
  logic [XLEN-1:0] instret_q;
  logic            retire;

  // Only the major opcode steers sequencing; the rest of IR feeds the datapath
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  mc_opcode_decode u_decode (
    .opcode  (instr[6:0]),
    .cls     (cls_d),
    .illegal (dec_illegal)
  );

  // Last cycle of an instruction: WB, store completion, or branch resolution
  assign retire = (state_q == ST_WB)
                | ((state_q == ST_MEM) & mem_ready & cls_q.store)
                | ((state_q == ST_EXEC) & cls_q.branch);

  // State sequencing, class capture at DECODE and the sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          cls_q <= cls_d;
          if (dec_illegal) begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cls_is_mem(cls_q))  state_q <= ST_MEM;
          else if (cls_q.branch)  state_q <= ST_FETCH;
          else                    state_q <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready) state_q <= cls_q.load ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          state_q <= ST_FETCH;
        end
        ST_TRAP: begin
          state_q <= ST_TRAP;
        end
        default: begin
          // Unused encodings are treated like an illegal instruction
          state_q   <= ST_TRAP;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^XLEN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + XLEN'(1);
    end
  end

  // Datapath controls decoded from state and class; forced low while in reset
  // so an in-flight memory request is dropped immediately
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    imm_en       = 1'b0;
    if (rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            pc_sel = PC_PLUS4;
          end
        end
        ST_DECODE: begin
          imm_en = 1'b1;
          // Branch target PC+imm is formed now and held in ALUOut for EXEC
          if (cls_d.branch) begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            alu_op    = ALU_ADD;
          end
        end
        ST_EXEC: begin
          if (cls_q.r) begin
            alu_op = ALU_FUNCT;
          end else if (cls_q.i_alu) begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_FUNCT;
          end else if (cls_is_mem(cls_q)) begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_ADD;
          end else if (cls_q.branch) begin
            alu_op = ALU_CMP;
            pc_we  = br_taken;
            pc_sel = PC_ALU;
          end else if (cls_q.jal || cls_q.auipc) begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            alu_op    = ALU_ADD;
          end else if (cls_q.jalr) begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_ADD;
          end else if (cls_q.lui) begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_PASSB;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = cls_q.store;
        end
        ST_WB: begin
          rf_we = 1'b1;
          if (cls_q.load)                  wb_sel = WB_MEM;
          else if (cls_q.jal || cls_q.jalr) wb_sel = WB_PC4;
          else                             wb_sel = WB_ALU;
          if (cls_q.jal) begin
            pc_we  = 1'b1;
            pc_sel = PC_ALU;
          end else if (cls_q.jalr) begin
            pc_we  = 1'b1;
            pc_sel = PC_JALR;
          end
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign illegal      = illegal_q;
  assign instret      = instret_q;
  assign pc_reset_val = RESET_PC;

endmodule
